// File: rtl/shift_pattern_pkg.sv
// Shared encodings and phase-selection helper for the shift-pattern sequencer.
package shift_pattern_pkg;

  typedef enum logic [1:0] {
    PH_SHL  = 2'd0,
    PH_SHR  = 2'd1,
    PH_ROL  = 2'd2,
    PH_JOHN = 2'd3
  } phase_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic   found;
    phase_e ph;
  } phase_sel_t;

  // Lowest enabled phase whose index is >= from; from=4 never matches.
  function automatic phase_sel_t find_phase(input logic [3:0] mask, input logic [2:0] from);
    phase_sel_t r;
    r.found = 1'b0;
    r.ph    = PH_SHL;
    for (int i = 3; i >= 0; i--) begin
      if (i >= int'(from) && mask[i]) begin
        r.found = 1'b1;
        r.ph    = phase_e'(i[1:0]);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_pattern_core.sv
// Pattern register: load has priority over a shift; the op selects the shift flavour.
module shift_pattern_core
  import shift_pattern_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d, shift_d;

  always_comb begin
    shift_d = q_q;
    case (phase_e'(op))
      PH_SHL:  shift_d = {q_q[WIDTH-2:0], 1'b0};
      PH_SHR:  shift_d = {1'b0, q_q[WIDTH-1:1]};
      PH_ROL:  shift_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      PH_JOHN: shift_d = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
      default: shift_d = q_q;
    endcase
  end

  always_comb begin
    q_d = q_q;
    if (load)    q_d = seed;
    else if (en) q_d = shift_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/shift_pattern_sequencer.sv
// Runs each enabled shift phase in ascending order for a programmed step count.
module shift_pattern_sequencer
  import shift_pattern_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  seed,
  input  logic [STEP_W-1:0] steps,
  input  logic [3:0]        mask,
  input  logic              hold,
  input  logic              abort,
  output logic [WIDTH-1:0]  q,
  output logic [1:0]        phase,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [3:0]        mask_q, mask_d;
  logic              done_q, done_d;
  logic              load, shift_en;
  phase_sel_t        first_ph, nxt_ph;

  assign first_ph = find_phase(mask, 3'd0);
  assign nxt_ph   = find_phase(mask_q, {1'b0, phase_q} + 3'd1);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    steps_d  = steps_q;
    mask_d   = mask_q;
    done_d   = 1'b0;
    load     = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          steps_d = steps;
          mask_d  = mask;
          if (steps == '0 || mask == 4'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            phase_d = first_ph.ph;
            cnt_d   = '0;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!hold) begin
          shift_en = 1'b1;
          if (cnt_q == steps_q - STEP_W'(1)) begin
            cnt_d = '0;
            // Last phase finishing ends the run on this same edge.
            if (nxt_ph.found) begin
              phase_d = nxt_ph.ph;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + STEP_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      phase_q <= PH_SHL;
      cnt_q   <= '0;
      steps_q <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      steps_q <= steps_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
    end
  end

  shift_pattern_core #(.WIDTH(WIDTH)) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .en   (shift_en),
    .op   (phase_q),
    .seed (seed),
    .q    (q)
  );

  assign phase = phase_q;
  assign busy  = (state_q == ST_RUN);
  assign done  = done_q;

endmodule
